armleocpu_avl_mem_responder: RTL and testbench

Avalon-MM slave that answers the single-beat read/write transactions issued by the core's bus masters, including the page-table walker, using a local 32-bit word memory. Inserts a configurable number of wait states and reports address and protocol errors on `avl_response`. Used as simulation/FPGA backing memory for page tables and as the bench counterpart for walker and cache verification.

---
 rtl/armleocpu_avl_mem_responder.sv | 143 ++++++++++++++
 tb/tb_armleocpu_avl_mem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_avl_mem_responder.sv
// Avalon-MM single-beat slave backed by a local word memory, with configurable
// wait states and SLVERR/DECODEERROR reporting on avl_response.
`timescale 1ns/1ps

module armleocpu_avl_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic [33:0] avl_address,
  input  logic        avl_read,
  input  logic        avl_write,
  input  logic [31:0] avl_writedata,
  input  logic [3:0]  avl_byteenable,
  output logic        avl_waitrequest,
  output logic        avl_readdatavalid,
  output logic [31:0] avl_readdata,
  output logic [1:0]  avl_response
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

  state_t      r_state;
  logic [3:0]  r_counter;
  logic [33:0] r_address;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_writedata;
  logic [3:0]  r_byteenable;
  logic        r_waitrequest;
  logic        r_readdatavalid;
  logic [31:0] r_readdata;
  logic [1:0]  r_response;
  logic [31:0] r_mem [DEPTH];

  logic                  w_idle;
  logic                  w_request;
  logic [33:0]           w_address;
  logic                  w_read;
  logic                  w_write;
  logic [31:0]           w_writedata;
  logic [3:0]            w_byteenable;
  logic                  w_enterRespond;
  logic [1:0]            w_response;
  logic [DEPTH_LOG2-1:0] w_index;
  logic                  w_commit;

  // With LATENCY=0 the response is decided straight from the bus, otherwise
  // from the copy captured in IDLE; one mux keeps both paths identical.
  assign w_idle       = (r_state == S_IDLE);
  assign w_request    = avl_read || avl_write;
  assign w_address    = w_idle ? avl_address    : r_address;
  assign w_read       = w_idle ? avl_read       : r_read;
  assign w_write      = w_idle ? avl_write      : r_write;
  assign w_writedata  = w_idle ? avl_writedata  : r_writedata;
  assign w_byteenable = w_idle ? avl_byteenable : r_byteenable;
  assign w_index      = w_address[DEPTH_LOG2+1:2];

  assign w_enterRespond = (w_idle && w_request && (LATENCY == 0)) ||
                          ((r_state == S_WAIT) && (r_counter == 4'd1));

  always_comb begin
    w_response = RESP_OKAY;
    if (w_read && w_write)
      w_response = RESP_SLVERR;
    else if (w_address[1:0] != 2'b00)
      w_response = RESP_SLVERR;
    else if (|w_address[33:DEPTH_LOG2+2])
      w_response = RESP_DECERR;
  end

  // Gated by reset so a write interrupted by reset never lands in memory.
  assign w_commit = async_rst_n && w_enterRespond && w_write && !w_read &&
                    (w_response == RESP_OKAY);

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byteenable[i])
          r_mem[w_index][8*i +: 8] <= w_writedata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state         <= S_IDLE;
      r_counter       <= 4'd0;
      r_address       <= 34'd0;
      r_read          <= 1'b0;
      r_write         <= 1'b0;
      r_writedata     <= 32'd0;
      r_byteenable    <= 4'd0;
      r_waitrequest   <= 1'b1;
      r_readdatavalid <= 1'b0;
      r_readdata      <= 32'd0;
      r_response      <= RESP_OKAY;
    end else begin
      r_waitrequest   <= 1'b1;
      r_readdatavalid <= 1'b0;
      r_readdata      <= 32'd0;
      r_response      <= RESP_OKAY;
      case (r_state)
        S_IDLE: begin
          if (w_request) begin
            r_address    <= avl_address;
            r_read       <= avl_read;
            r_write      <= avl_write;
            r_writedata  <= avl_writedata;
            r_byteenable <= avl_byteenable;
            r_counter    <= 4'(LATENCY);
            r_state      <= w_enterRespond ? S_RESPOND : S_WAIT;
          end
        end
        S_WAIT: begin
          r_counter <= r_counter - 4'd1;
          if (w_enterRespond)
            r_state <= S_RESPOND;
        end
        S_RESPOND: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
      if (w_enterRespond) begin
        r_waitrequest   <= 1'b0;
        r_readdatavalid <= w_read;
        r_response      <= w_response;
        r_readdata      <= (w_read && (w_response == RESP_OKAY)) ? r_mem[w_index] : 32'd0;
      end
    end
  end

  assign avl_waitrequest   = r_waitrequest;
  assign avl_readdatavalid = r_readdatavalid;
  assign avl_readdata      = r_readdata;
  assign avl_response      = r_response;

endmodule

// File: tb/tb_armleocpu_avl_mem_responder.sv
// Scoreboard bench: the driver predicts each response from a word-array model and
// queues it; a monitor pops and compares whenever the DUT drops waitrequest.
`timescale 1ns/1ps

module tb_armleocpu_avl_mem_responder;

  localparam int DEPTH_LOG2 = 10;
  localparam int LATENCY    = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic        clk;
  logic        async_rst_n;
  logic [33:0] avl_address;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic        avl_waitrequest;
  logic        avl_readdatavalid;
  logic [31:0] avl_readdata;
  logic [1:0]  avl_response;

  typedef struct {
    logic        rdv;
    logic [1:0]  resp;
    logic [31:0] data;
    int          issueCycle;
    string       name;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] model [int];
  int          checks = 0;
  int          errors = 0;
  int          cycleCnt = 0;
  bit          prevLow = 1'b0;

  armleocpu_avl_mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)) dut (
    .clk               (clk),
    .async_rst_n       (async_rst_n),
    .avl_address       (avl_address),
    .avl_read          (avl_read),
    .avl_write         (avl_write),
    .avl_writedata     (avl_writedata),
    .avl_byteenable    (avl_byteenable),
    .avl_waitrequest   (avl_waitrequest),
    .avl_readdatavalid (avl_readdatavalid),
    .avl_readdata      (avl_readdata),
    .avl_response      (avl_response)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: a sparse array of words; byte lanes merged with a mask.
  function automatic exp_t predict(input logic [33:0] addr, input bit rd, input bit wr,
                                   input logic [31:0] data, input logic [3:0] be);
    exp_t e;
    longint unsigned wordIdx;
    logic [31:0] mask, oldv;
    wordIdx = 64'(addr) / 4;
    e.rdv  = rd;
    e.data = 32'd0;
    e.issueCycle = 0;
    e.name = "";
    if (rd && wr)
      e.resp = 2'b10;
    else if (addr % 4 != 0)
      e.resp = 2'b10;
    else if (wordIdx >= DEPTH)
      e.resp = 2'b11;
    else begin
      e.resp = 2'b00;
      oldv = model.exists(int'(wordIdx)) ? model[int'(wordIdx)] : 32'd0;
      if (rd) e.data = oldv;
      if (wr) begin
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        model[int'(wordIdx)] = (oldv & ~mask) | (data & mask);
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [33:0] addr, input bit rd, input bit wr,
                               input logic [31:0] data, input logic [3:0] be,
                               input bit dropEarly, input string name);
    exp_t e;
    bit accepted;
    @(negedge clk);
    e = predict(addr, rd, wr, data, be);
    e.issueCycle = cycleCnt;
    e.name = name;
    expQ.push_back(e);
    avl_address    = addr;
    avl_read       = rd;
    avl_write      = wr;
    avl_writedata  = data;
    avl_byteenable = be;
    accepted = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (dropEarly) begin
        avl_read  = 1'b0;
        avl_write = 1'b0;
      end
      if (!avl_waitrequest) begin
        accepted = 1'b1;
        break;
      end
    end
    avl_read  = 1'b0;
    avl_write = 1'b0;
    checkOutput({name, " accepted"}, {31'd0, accepted}, 32'd1);
    @(posedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (async_rst_n && !avl_waitrequest) begin
      checkOutput("waitrequest low one cycle", {31'd0, prevLow}, 32'd0);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected response: got response=%0d, required none", avl_response);
      end else begin
        e = expQ.pop_front();
        checkOutput({e.name, " readdatavalid"}, {31'd0, avl_readdatavalid}, {31'd0, e.rdv});
        checkOutput({e.name, " response"}, {30'd0, avl_response}, {30'd0, e.resp});
        if (e.rdv) checkOutput({e.name, " readdata"}, avl_readdata, e.data);
        checkOutput({e.name, " latency"}, 32'(cycleCnt - e.issueCycle), 32'(1 + LATENCY));
      end
    end
    prevLow = async_rst_n && !avl_waitrequest;
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " waitrequest"}, {31'd0, avl_waitrequest}, 32'd1);
    checkOutput({tag, " readdatavalid"}, {31'd0, avl_readdatavalid}, 32'd0);
    checkOutput({tag, " readdata"}, avl_readdata, 32'd0);
    checkOutput({tag, " response"}, {30'd0, avl_response}, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [33:0] addr;
    logic [31:0] oldWord;
    int kind;
    bit rd, wr;

    async_rst_n    = 1'b0;
    avl_address    = 34'd0;
    avl_read       = 1'b0;
    avl_write      = 1'b0;
    avl_writedata  = 32'd0;
    avl_byteenable = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    async_rst_n = 1'b1;
    @(posedge clk);

    applyStimulus(34'h40, 0, 1, 32'hDEADBEEF, 4'hF, 0, "write 0x40");
    applyStimulus(34'h40, 1, 0, 32'h0, 4'hF, 0, "read 0x40");
    applyStimulus(34'h44, 0, 1, 32'h11223344, 4'hF, 0, "write 0x44");
    applyStimulus(34'h44, 0, 1, 32'hAABBCCDD, 4'b0101, 0, "byteenable write");
    applyStimulus(34'h44, 1, 0, 32'h0, 4'hF, 0, "byteenable read");
    applyStimulus(34'h1000, 1, 0, 32'h0, 4'hF, 0, "decode error read");
    applyStimulus(34'h42, 1, 0, 32'h0, 4'hF, 0, "misaligned read");
    applyStimulus(34'h40, 1, 1, 32'h12345678, 4'hF, 0, "read+write");
    applyStimulus(34'h40, 1, 0, 32'h0, 4'hF, 0, "read after read+write");
    applyStimulus(34'(4 * (DEPTH - 1)), 0, 1, 32'hCAFEF00D, 4'hF, 0, "write last word");
    applyStimulus(34'(4 * (DEPTH - 1)), 1, 0, 32'h0, 4'hF, 1, "read last word");

    for (int w = 0; w < 64; w++)
      applyStimulus(34'(4 * w), 0, 1, $urandom, 4'hF, 0, "preload");

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      rd = $urandom_range(0, 1) == 1;
      wr = !rd;
      addr = 34'(4 * $urandom_range(0, 63));
      case (kind)
        6: addr = addr + 34'($urandom_range(1, 3));
        7: addr = ({2'($urandom), 32'($urandom)} | 34'h1000) & ~34'h3;
        8: begin rd = 1; wr = 1; end
        9: begin rd = 1; wr = 0; end
        default: ;
      endcase
      applyStimulus(addr, rd, wr, $urandom, 4'($urandom), $urandom_range(0, 3) == 0, "random");
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset lands while a write is waiting; the word must keep its old value.
    oldWord = model[16];
    @(negedge clk);
    avl_address    = 34'h40;
    avl_write      = 1'b1;
    avl_writedata  = ~oldWord;
    avl_byteenable = 4'hF;
    @(posedge clk);
    @(negedge clk);
    async_rst_n = 1'b0;
    avl_write   = 1'b0;
    #1;
    checkResetOutputs("mid-wait reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_rst_n = 1'b1;
    @(posedge clk);
    applyStimulus(34'h40, 1, 0, 32'h0, 4'hF, 0, "read after reset");

    repeat (5) @(posedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
